// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one delay timer among N_REQ requesters.
// The owner is granted the timer, and its ack pulses when the loaded delay has expired.
`timescale 1ns/1ps

module timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             done_o
);

  // One extra bit so that count+1 never wraps, even for an all-ones count.
  logic [WIDTH:0] r_cnt;
  logic           r_run;

  // Load on start, then count down; done is reported count+2 cycles after start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= {(WIDTH+1){1'b0}};
      r_run <= 1'b0;
    end else if (start_i) begin
      r_cnt <= {1'b0, count_i} + {{WIDTH{1'b0}}, 1'b1};
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == {(WIDTH+1){1'b0}}) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - {{WIDTH{1'b0}}, 1'b1};
      end
    end
  end

  assign done_o = r_run & (r_cnt == {(WIDTH+1){1'b0}});

endmodule

module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] count_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       ack_o,
  output logic                   busy_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [IW-1:0]    r_owner, w_owner_nx;
  logic [IW-1:0]    r_ptr, w_ptr_nx;
  logic [WIDTH-1:0] r_count, w_count_nx;

  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [WIDTH-1:0] w_pick_cnt;
  logic [IW-1:0]    w_owner_inc;
  logic [N_REQ-1:0] w_owner_oh;
  logic             w_own_req;
  logic             w_active;
  logic             w_abort;
  logic             w_done;
  logic             w_tmr_rst;
  logic             w_tmr_start;

  // First pending request at or above the pointer, wrapping around.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = {IW{1'b0}};
    w_pick_cnt = {WIDTH{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req_i[(int'(r_ptr) + k) % N_REQ]) begin
        w_found    = 1'b1;
        w_pick     = IW'((int'(r_ptr) + k) % N_REQ);
        w_pick_cnt = count_i[((int'(r_ptr) + k) % N_REQ) * WIDTH +: WIDTH];
      end else begin
        w_found    = w_found;
      end
    end
  end

  assign w_owner_inc = (r_owner == IW'(N_REQ - 1)) ? {IW{1'b0}} : r_owner + {{(IW-1){1'b0}}, 1'b1};
  assign w_owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_own_req   = req_i[r_owner];
  assign w_active    = (r_state == S_START) | (r_state == S_RUN);
  assign w_abort     = (r_state == S_RUN) & ~w_own_req;
  assign w_tmr_rst   = ~rst_ni | w_abort;
  assign w_tmr_start = (r_state == S_START);

  // Next-state logic; abandon wins over a coincident done.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_count_nx = r_count;
    w_ptr_nx   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_START;
          w_owner_nx = w_pick;
          w_count_nx = w_pick_cnt;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_START: begin
        w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (!w_own_req || w_done) begin
          w_state_nx = S_IDLE;
          w_ptr_nx   = w_owner_inc;
        end else begin
          w_state_nx = S_RUN;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // FSM state, owner, latched delay and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_owner <= {IW{1'b0}};
      r_ptr   <= {IW{1'b0}};
      r_count <= {WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_count <= w_count_nx;
    end
  end

  timer #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (w_tmr_rst),
    .start_i (w_tmr_start),
    .count_i (r_count),
    .done_o  (w_done)
  );

  assign grant_o = w_active ? w_owner_oh : {N_REQ{1'b0}};
  assign ack_o   = ((r_state == S_RUN) && w_own_req && w_done) ? w_owner_oh : {N_REQ{1'b0}};
  assign busy_o  = w_active;

endmodule
